// File: rtl/stopwatch_ctl.sv
// MM:SS BCD stopwatch feeding the 4-digit display scanner, with run/pause, lap freeze and clear.
// Build option: define STOPWATCH_WRAP_EN to wrap 59:59 -> 00:00 instead of saturating with a forced pause.
module stopwatch_ctl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned PRE_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

`ifdef STOPWATCH_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre;
  logic [3:0]       sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0]       sec_ones_nxt, sec_tens_nxt, min_ones_nxt, min_tens_nxt;
  logic [3:0]       snap_so, snap_st, snap_mo, snap_mt;
  logic             running_nxt;
  logic             tick_c, at_max_c, ovf_event_c, lap_toggle_c;

  assign tick_c       = (state == RUN) && (pre == PRE_LAST);
  assign at_max_c     = (min_tens == 4'd5) && (min_ones == 4'd9) &&
                        (sec_tens == 4'd5) && (sec_ones == 4'd9);
  assign ovf_event_c  = tick_c && at_max_c;
  assign lap_toggle_c = lap && (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear dominates all other pulses
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_nxt = RUN;
        RUN: begin
          if (start_stop)                 state_nxt = PAUSE;
          else if (ovf_event_c && !WRAP_EN) state_nxt = PAUSE;
        end
        PAUSE:   if (start_stop && !(overflow && !WRAP_EN)) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs (registered below)
  always_comb begin
    running_nxt = 1'b0;
    if (state_nxt == RUN) running_nxt = 1'b1;
  end

  // BCD increment with carry chain; saturation holds 59:59 when wrap is off
  always_comb begin
    sec_ones_nxt = sec_ones;
    sec_tens_nxt = sec_tens;
    min_ones_nxt = min_ones;
    min_tens_nxt = min_tens;
    if (tick_c && !(at_max_c && !WRAP_EN)) begin
      if (sec_ones != 4'd9) begin
        sec_ones_nxt = sec_ones + 4'd1;
      end else begin
        sec_ones_nxt = 4'd0;
        if (sec_tens != 4'd5) begin
          sec_tens_nxt = sec_tens + 4'd1;
        end else begin
          sec_tens_nxt = 4'd0;
          if (min_ones != 4'd9) begin
            min_ones_nxt = min_ones + 4'd1;
          end else begin
            min_ones_nxt = 4'd0;
            if (min_tens != 4'd5) min_tens_nxt = min_tens + 4'd1;
            else                  min_tens_nxt = 4'd0;
          end
        end
      end
    end
  end

  // Datapath registers; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pre        <= '0;
      sec_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      min_ones   <= 4'd0;
      min_tens   <= 4'd0;
      snap_so    <= 4'd0;
      snap_st    <= 4'd0;
      snap_mo    <= 4'd0;
      snap_mt    <= 4'd0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      running    <= 1'b0;
      digit3     <= 4'd0;
      digit2     <= 4'd0;
      digit1     <= 4'd0;
      digit0     <= 4'd0;
    end else begin
      if (state == IDLE && state_nxt == RUN) pre <= '0;
      else if (state == RUN)                 pre <= tick_c ? '0 : pre + PRE_W'(1);

      sec_ones <= sec_ones_nxt;
      sec_tens <= sec_tens_nxt;
      min_ones <= min_ones_nxt;
      min_tens <= min_tens_nxt;

      // Snapshot is taken from the pre-tick time on the freeze edge
      if (lap_toggle_c) begin
        lap_active <= !lap_active;
        if (!lap_active) begin
          snap_so <= sec_ones;
          snap_st <= sec_tens;
          snap_mo <= min_ones;
          snap_mt <= min_tens;
        end
      end

      if (ovf_event_c) overflow <= 1'b1;
      running <= running_nxt;

      digit3 <= lap_active ? snap_mt : min_tens;
      digit2 <= lap_active ? snap_mo : min_ones;
      digit1 <= lap_active ? snap_st : sec_tens;
      digit0 <= lap_active ? snap_so : sec_ones;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Scoreboard bench for stopwatch_ctl with TICK_DIV=4: stimulus queues expected outputs, a negedge monitor checks them.
module tb_stopwatch_ctl;

`ifdef STOPWATCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start_stop, lap, clear;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running, lap_active, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [15:0] d;
    logic       run;
    logic       lapa;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  stopwatch_ctl #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: drains every pending expectation against the outputs at negedge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".digits"}, {digit3, digit2, digit1, digit0}, e.d);
      chk({e.name, ".running"}, 16'(running), 16'(e.run));
      chk({e.name, ".lap_active"}, 16'(lap_active), 16'(e.lapa));
      chk({e.name, ".overflow"}, 16'(overflow), 16'(e.ovf));
    end
  end

  task automatic expect_out(input string name, input logic [15:0] d,
                            input logic r, input logic l, input logic o);
    exp_t e;
    e.name = name; e.d = d; e.run = r; e.lapa = l; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step(2);
    expect_out("reset", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;
    step(1);

    // Run to 00:09, pause, resume keeping the partial second
    pulse_ss();
    step(37);  expect_out("run9",        16'h0009, 1, 0, 0);
    pulse_ss();
    step(20);  expect_out("pause",       16'h0009, 0, 0, 0);
    pulse_ss();
    step(2);   expect_out("resume_pre",  16'h0009, 1, 0, 0);
    step(1);   expect_out("resume_tick", 16'h0010, 1, 0, 0);

    // Lap freeze at 01:23, release at 01:31
    step(292);
    pulse_lap();
    step(1);   expect_out("lap_freeze",   16'h0123, 1, 1, 0);
    step(31);  expect_out("lap_hold",     16'h0123, 1, 1, 0);
    pulse_lap();
    expect_out("lap_off_edge", 16'h0123, 1, 0, 0);
    step(1);   expect_out("lap_release",  16'h0131, 1, 0, 0);

    // Clear dominates start_stop and lap
    pulse_lap();
    step(1);
    clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
    step(1);
    clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
    expect_out("clear", 16'h0000, 0, 0, 0);
    step(10);  expect_out("idle_hold", 16'h0000, 0, 0, 0);

    // Synchronous reset at 12:34
    pulse_ss();
    step(3017); expect_out("t1234", 16'h1234, 1, 0, 0);
    rst_n = 1'b0;
    expect_out("rst_async", 16'h1234, 1, 0, 0);
    step(1);    expect_out("rst_sync", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;
    step(1);

    // 59:59 rollover event
    pulse_ss();
    step(14399); expect_out("pre_ovf", 16'h5959, 1, 0, 0);
    step(1);     expect_out("ovf", 16'h5959, WRAP, 0, 1);
    step(1);     expect_out("ovf_next", WRAP ? 16'h0000 : 16'h5959, WRAP, 0, 1);
    pulse_ss();
    expect_out("ss1", WRAP ? 16'h0000 : 16'h5959, 0, 0, 1);
    pulse_ss();
    expect_out("ss2", WRAP ? 16'h0000 : 16'h5959, WRAP, 0, 1);

    clear = 1'b1; step(1); clear = 1'b0;
    expect_out("final_clear", 16'h0000, 0, 0, 0);

    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
